// File: rtl/chs_pkg.sv
// Shared types and constants for the cool/heat system temperature front end.
package chs_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        UPDATE = 2'd1,
        FAULT  = 2'd2
    } chs_state_e;

    localparam int unsigned RESET_TEMP_DEF = 25;
    localparam logic [7:0]  SPEED_SAT      = 8'hFF;

endpackage

// File: rtl/chs_speed_map.sv
// Maps averaged temperature and setpoint to a saturated speed duty-cycle.
module chs_speed_map
    import chs_pkg::*;
#(
    parameter int unsigned GAIN_SHIFT = 2
) (
    input  logic [7:0] avg,
    input  logic [7:0] setpoint,
    output logic [7:0] speed
);

    localparam int unsigned WIDE_W = 8 + GAIN_SHIFT + 1;

    logic [7:0]        diff;
    logic [WIDE_W-1:0] scaled;

    // Absolute difference, gain shift at full width, then clamp to 8 bits.
    always_comb begin
        diff   = (avg >= setpoint) ? (avg - setpoint) : (setpoint - avg);
        scaled = WIDE_W'(diff) << GAIN_SHIFT;
        speed  = (scaled > WIDE_W'(SPEED_SAT)) ? SPEED_SAT : scaled[7:0];
    end

endmodule

// File: rtl/chs_temp_frontend.sv
// Sensor sample averager producing chs_conf/speed with stalled-sensor detection.
module chs_temp_frontend
    import chs_pkg::*;
#(
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned GAIN_SHIFT = 2,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned RESET_TEMP = RESET_TEMP_DEF
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       sen_valid,
    output logic       sen_ready,
    input  logic [7:0] sen_data,
    input  logic [7:0] setpoint,
    output logic [7:0] chs_conf,
    output logic [7:0] speed,
    output logic       conf_valid,
    output logic       sensor_fault
);

    localparam int unsigned ACC_W  = 8 + AVG_LOG2;
    localparam int unsigned CNT_W  = AVG_LOG2 + 1;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned N      = 1 << AVG_LOG2;

    chs_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [7:0]        conf_d;
    logic [7:0]        speed_d;
    logic              valid_d;
    logic              fault_d;
    logic              accept;
    logic [7:0]        avg;
    logic [7:0]        speed_c;

    assign accept = sen_valid && sen_ready;
    assign avg    = acc_q[ACC_W-1:AVG_LOG2];

    chs_speed_map #(
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_speed_map (
        .avg      (avg),
        .setpoint (setpoint),
        .speed    (speed_c)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            cnt_q        <= '0;
            tcnt_q       <= '0;
            sen_ready    <= 1'b1;
            chs_conf     <= 8'(RESET_TEMP);
            speed        <= 8'd0;
            conf_valid   <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            tcnt_q       <= tcnt_d;
            sen_ready    <= (state_d != UPDATE);
            chs_conf     <= conf_d;
            speed        <= speed_d;
            conf_valid   <= valid_d;
            sensor_fault <= fault_d;
        end
    end

    // Next-state and next-output decode; an accept always beats a timeout.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        conf_d  = chs_conf;
        speed_d = speed;
        valid_d = 1'b0;
        fault_d = sensor_fault;

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d  = acc_q + ACC_W'(sen_data);
                    cnt_d  = cnt_q + CNT_W'(1);
                    tcnt_d = '0;
                    if (cnt_d == CNT_W'(N)) begin
                        state_d = UPDATE;
                    end
                end else if (tcnt_q >= TCNT_W'(TIMEOUT - 1)) begin
                    tcnt_d  = TCNT_W'(TIMEOUT);
                    acc_d   = '0;
                    cnt_d   = '0;
                    conf_d  = setpoint;
                    speed_d = 8'd0;
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            UPDATE: begin
                conf_d  = avg;
                speed_d = speed_c;
                valid_d = 1'b1;
                fault_d = 1'b0;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ACCUM;
            end
            FAULT: begin
                if (accept) begin
                    acc_d   = ACC_W'(sen_data);
                    cnt_d   = CNT_W'(1);
                    tcnt_d  = '0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

endmodule

// File: doc/chs_temp_frontend.md
Name: chs_temp_frontend

Overview:
Upstream stage of the cool/heat system. It accepts raw 8-bit temperature samples from the sensor over a valid/ready handshake and averages each block of 2^AVG_LOG2 samples. From each average it produces the chs_conf temperature word and the 8-bit speed duty-cycle that the cool/heat system consumes. It also detects a stalled sensor and forces safe outputs until the sensor recovers.

Parameters:
AVG_LOG2, 2, log2 of samples per average (N = 2^AVG_LOG2); legal range 1..4.
GAIN_SHIFT, 2, speed = |avg - setpoint| << GAIN_SHIFT, saturated to 255.
TIMEOUT, 16, consecutive cycles without an accepted sample before a fault is declared; must be >= 2.
RESET_TEMP, 25, chs_conf value after reset.

Ports:
clk  input  1  clock; all state updates on the rising edge.
arst  input  1  asynchronous, active-high reset.
sen_valid  input  1  sensor sample valid.
sen_ready  output  1  block can accept a sample.
sen_data  input  8  unsigned sample, degrees C.
setpoint  input  8  unsigned target temperature; sampled combinationally at UPDATE and at fault entry.
chs_conf  output  8  registered averaged temperature, drives the cool/heat system's chs_conf.
speed  output  8  registered duty-cycle, drives the cool/heat system's speed.
conf_valid  output  1  one-cycle pulse when chs_conf and speed take a new average.
sensor_fault  output  1  sticky fault flag.

Behaviour:
- Clock and reset: single clock clk; reset arst is asynchronous and active-high.
- Reset values:
  - chs_conf = RESET_TEMP, speed = 0, conf_valid = 0, sensor_fault = 0.
  - state = ACCUM; accumulator, sample count and timeout counter all = 0.
- Handshake:
  - A sample is accepted on a rising edge when sen_valid && sen_ready.
  - sen_ready = 1 in ACCUM and FAULT, 0 in UPDATE. There is no combinational path from sen_valid to sen_ready.
  - A sample held with sen_valid=1 while sen_ready=0 is not lost; it is taken on the next ready cycle.
- Accumulator: width 8+AVG_LOG2 bits, so it never overflows. The sample count is AVG_LOG2+1 bits.
- States:
  - ACCUM: on accept, acc += sen_data and count += 1. When the accepted sample is the Nth, go to UPDATE.
  - UPDATE (exactly one cycle), at the edge that leaves it:
    - avg = acc >> AVG_LOG2 (truncation, no rounding); chs_conf <= avg.
    - speed <= min(255, |avg - setpoint| << GAIN_SHIFT), computed at 8+GAIN_SHIFT+1 bits before saturation.
    - conf_valid <= 1 for that one cycle; sensor_fault <= 0.
    - acc and count cleared; go to ACCUM.
  - FAULT: chs_conf and speed hold their fault values. On the first accept, go to ACCUM with count=1 and acc=sen_data.
- Latency: the Nth sample is accepted at edge k; UPDATE spans k..k+1; outputs and conf_valid are visible after edge k+1. The next accept is possible at edge k+2.
- Timeout counter:
  - Counts cycles in ACCUM with no accept; cleared on every accept; saturates at TIMEOUT.
  - When it reaches TIMEOUT, at that edge: sensor_fault <= 1, chs_conf <= setpoint, speed <= 0, conf_valid stays 0, partial acc/count discarded, state <= FAULT.
  - The counter is frozen in UPDATE and FAULT.
- Simultaneous accept and timeout in the same cycle: the accept wins, the counter clears and no fault is raised.
- sensor_fault clears only at the next UPDATE, i.e. after a full fresh average of N samples.
- arst asserted mid-accumulation discards partial data immediately and restores all reset values.

Decomposition:
- Shared package chs_pkg:
  - state enum {ACCUM, UPDATE, FAULT}.
  - RESET_TEMP default and a speed saturation constant of 8'hFF.
- One combinational sub-module, chs_speed_map: inputs avg[7:0], setpoint[7:0]; output speed[7:0]. It computes abs-diff, shift and saturate, and can be unit-tested in isolation.

Test Plan (AVG_LOG2=2, GAIN_SHIFT=2, TIMEOUT=16 unless noted):
1. Reset: pulse arst asynchronously mid-cycle -> chs_conf=25, speed=0, conf_valid=0, sensor_fault=0, sen_ready=1 immediately.
2. Basic average: setpoint=20, back-to-back samples 20,22,24,26 -> sen_ready low for 1 cycle after the 4th accept; chs_conf=23, speed=12, one-cycle conf_valid 2 edges after the 4th accept.
3. Truncation and saturation: samples 10,10,10,11, setpoint=10 -> chs_conf=10, speed=0; then 200,200,200,200, setpoint=20 -> chs_conf=200, speed=255 (720 saturated); also setpoint above avg (avg 10, setpoint 30) -> speed=80.
4. Backpressure: sen_valid held high continuously with an incrementing sample each accept -> no sample skipped or duplicated across UPDATE; two consecutive averages are correct.
5. Timeout: accept 2 samples, then sen_valid=0 for 16 cycles -> sensor_fault=1, chs_conf=setpoint, speed=0, no conf_valid; then 4 samples 30 with setpoint 20 -> chs_conf=30, speed=40, sensor_fault=0. Variant with an accept on the 16th cycle -> no fault.
6. Reset mid-operation: arst after 3 of 4 samples, then 4 samples of 40 -> chs_conf=40 (pre-reset samples not included).
